// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds state encodings, opcode/funct constants, ALU-op / PC-source / ALU-B-source codes, the
// per-state control word carried from ctrl_outdec to multicycle_ctrl, and the legality check
// for the supported instruction subset (addu, subu, ori, lw, sw, beq, j).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRex    = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StOriEx  = 4'd9,
    StOriWb  = 4'd10,
    StJump   = 4'd11,
    StHalt   = 4'd12
  } state_e;

  localparam logic [5:0] OpR   = 6'b000000;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpOri = 6'b001101;
  localparam logic [5:0] OpJ   = 6'b000010;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10,
    AluOr    = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    PcAlu    = 2'b00,
    PcAluOut = 2'b01,
    PcJump   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    SrcbB     = 2'b00,
    Srcb4     = 2'b01,
    SrcbImm   = 2'b10,
    SrcbImmSh = 2'b11
  } srcb_e;

  // fetch_wr marks the FETCH commit (ir_write + pc_write) that only fires on mem ack.
  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    iord;
    logic    fetch_wr;
    logic    pc_write;
    logic    pc_write_cond;
    pc_src_e pc_src;
    logic    alusrc_a;
    srcb_e   alusrc_b;
    logic    ext_zero;
    aluop_e  aluop;
    logic    regdst;
    logic    memtoreg;
    logic    regwrite;
  } ctrl_word_t;

  function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
    logic ok;
    case (op)
      OpR:                            ok = (fn == FnAddu) || (fn == FnSubu);
      OpLw, OpSw, OpBeq, OpOri, OpJ:  ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port handshake between the control unit (master) and memory (slave).
//   mem_req : access request, held until mem_ack
//   mem_we  : 1 = write, 0 = read
//   mem_ack : memory completed the current request this cycle
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (output mem_req, output mem_we, input mem_ack);
  modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/ctrl_outdec.sv
// Purely combinational state -> control-word decode for the multicycle sequencer.
//   state : current sequencer state
//   cw    : raw control word for that state (not yet qualified by ack, zero or reset)
module ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      StFetch: begin
        cw.mem_req  = 1'b1;
        cw.fetch_wr = 1'b1;
        cw.alusrc_b = Srcb4;
        cw.aluop    = AluAdd;
        cw.pc_src   = PcAlu;
      end
      StDecode: begin
        // Branch target precomputed here while the register file is read.
        cw.alusrc_b = SrcbImmSh;
        cw.aluop    = AluAdd;
      end
      StMemAdr: begin
        cw.alusrc_a = 1'b1;
        cw.alusrc_b = SrcbImm;
        cw.aluop    = AluAdd;
      end
      StMemRd: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      StMemWb: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      StMemWr: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
        cw.mem_we  = 1'b1;
      end
      StRex: begin
        cw.alusrc_a = 1'b1;
        cw.alusrc_b = SrcbB;
        cw.aluop    = AluFunct;
      end
      StRwb: begin
        cw.regwrite = 1'b1;
        cw.regdst   = 1'b1;
      end
      StBranch: begin
        cw.alusrc_a      = 1'b1;
        cw.alusrc_b      = SrcbB;
        cw.aluop         = AluSub;
        cw.pc_write_cond = 1'b1;
        cw.pc_src        = PcAluOut;
      end
      StOriEx: begin
        cw.alusrc_a = 1'b1;
        cw.alusrc_b = SrcbImm;
        cw.ext_zero = 1'b1;
        cw.aluop    = AluOr;
      end
      StOriWb: begin
        cw.regwrite = 1'b1;
      end
      StJump: begin
        cw.pc_write = 1'b1;
        cw.pc_src   = PcJump;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer (addu, subu, ori, lw, sw, beq, j).
// Holds the state register, next-state logic and mem_ack qualification; the per-state control
// word comes from ctrl_outdec. Every output is forced low while rst is high.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   opcode, funct   : instruction register fields, valid from DECODE onward
//   zero            : ALU zero flag
//   mem             : memory handshake (mem_req/mem_we out, mem_ack in)
//   iord .. regwrite: datapath selects and enables
//   illegal         : unsupported instruction decoded
//   state           : current state, for debug
// Parameter RESET_PC_WRITE: pulse pc_write in the first cycle after reset release.
// Build option ILLEGAL_TRAP_EN: illegal instructions trap into HALT instead of acting as NOPs.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit RESET_PC_WRITE = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic                      zero,
  multicycle_ctrl_if.master         mem,
  output logic                      iord,
  output logic                      ir_write,
  output logic                      pc_en,
  output logic [1:0]                pc_src,
  output logic                      alusrc_a,
  output logic [1:0]                alusrc_b,
  output logic                      ext_zero,
  output logic [1:0]                aluop,
  output logic                      regdst,
  output logic                      memtoreg,
  output logic                      regwrite,
  output logic                      illegal,
  output logic [3:0]                state
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e IllegalNext = StHalt;
`else
  localparam state_e IllegalNext = StFetch;
`endif

  state_e     state_q, state_d;
  logic       pc_init_q;
  ctrl_word_t cw;
  logic       ack;
  logic       legal;
  logic       pc_write;
  logic       illegal_raw;

  ctrl_outdec u_outdec (
    .state (state_q),
    .cw    (cw)
  );

  // An ack only counts while a request is actually outstanding.
  assign ack   = cw.mem_req & mem.mem_ack;
  assign legal = is_legal(opcode, funct);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_init_q <= RESET_PC_WRITE;
    end else begin
      state_q   <= state_d;
      pc_init_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (ack) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = legal ? StRex : IllegalNext;
          OpBeq:      state_d = StBranch;
          OpOri:      state_d = StOriEx;
          OpJ:        state_d = StJump;
          default:    state_d = IllegalNext;
        endcase
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (ack) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (ack) state_d = StFetch;
      StRex:    state_d = StRwb;
      StRwb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StOriEx:  state_d = StOriWb;
      StOriWb:  state_d = StFetch;
      StJump:   state_d = StFetch;
`ifdef ILLEGAL_TRAP_EN
      StHalt:   state_d = StHalt;
`else
      StHalt:   state_d = StFetch;
`endif
      default:  state_d = StFetch;
    endcase
  end

  // pc_init_q is only set in the first cycle out of reset, which is always FETCH.
  assign pc_write = cw.pc_write | (cw.fetch_wr & ack) | (pc_init_q & (state_q == StFetch));

`ifdef ILLEGAL_TRAP_EN
  assign illegal_raw = (state_q == StHalt) | ((state_q == StDecode) & ~legal);
`else
  assign illegal_raw = (state_q == StDecode) & ~legal;
`endif

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    alusrc_a    = 1'b0;
    alusrc_b    = 2'b00;
    ext_zero    = 1'b0;
    aluop       = 2'b00;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    illegal     = 1'b0;
    // Reset must silence the port immediately, even though FETCH itself requests memory.
    if (!rst) begin
      mem.mem_req = cw.mem_req;
      mem.mem_we  = cw.mem_we;
      iord        = cw.iord;
      ir_write    = cw.fetch_wr & ack;
      pc_en       = pc_write | (cw.pc_write_cond & zero);
      pc_src      = cw.pc_src;
      alusrc_a    = cw.alusrc_a;
      alusrc_b    = cw.alusrc_b;
      ext_zero    = cw.ext_zero;
      aluop       = cw.aluop;
      regdst      = cw.regdst;
      memtoreg    = cw.memtoreg;
      regwrite    = cw.regwrite;
      illegal     = illegal_raw;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle expected control words are pushed to a scoreboard
// as stimulus is driven and popped/compared at the following falling edge.
module tb_multicycle_ctrl;

  localparam logic [3:0] SF = 4'd0, SD = 4'd1, SMA = 4'd2, SMR = 4'd3, SMWB = 4'd4,
                         SMW = 4'd5, SRX = 4'd6, SRW = 4'd7, SBR = 4'd8, SOX = 4'd9,
                         SOW = 4'd10, SJ = 4'd11, SH = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ORI = 6'b001101, OP_J = 6'b000010;

  typedef struct {
    logic [3:0] st;
    bit         a;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero_v;
  logic       ack;
  bit         exp_ill;
  int         compared = 0;
  int         mismatched = 0;

  logic [20:0] sb[$];
  bit          pc_q[$];
  step_t       steps[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if bus2 ();
  assign bus.mem_ack  = ack;
  assign bus2.mem_ack = ack;

  logic       iord, ir_write, pc_en, alusrc_a, ext_zero, regdst, memtoreg, regwrite, illegal;
  logic [1:0] pc_src, alusrc_b, aluop;
  logic [3:0] state;

  logic       d2_iord, d2_ir_write, d2_pc_en, d2_alusrc_a, d2_ext_zero, d2_regdst;
  logic       d2_memtoreg, d2_regwrite, d2_illegal;
  logic [1:0] d2_pc_src, d2_alusrc_b, d2_aluop;
  logic [3:0] d2_state;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero_v), .mem(bus),
    .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alusrc_a(alusrc_a),
    .alusrc_b(alusrc_b), .ext_zero(ext_zero), .aluop(aluop), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal), .state(state)
  );

  multicycle_ctrl #(.RESET_PC_WRITE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero_v), .mem(bus2),
    .iord(d2_iord), .ir_write(d2_ir_write), .pc_en(d2_pc_en), .pc_src(d2_pc_src),
    .alusrc_a(d2_alusrc_a), .alusrc_b(d2_alusrc_b), .ext_zero(d2_ext_zero), .aluop(d2_aluop),
    .regdst(d2_regdst), .memtoreg(d2_memtoreg), .regwrite(d2_regwrite),
    .illegal(d2_illegal), .state(d2_state)
  );

  wire [20:0] obs = {state, bus.mem_req, bus.mem_we, iord, ir_write, pc_en, pc_src, alusrc_a,
                     alusrc_b, ext_zero, aluop, regdst, memtoreg, regwrite, illegal};

  // Expected outputs for one cycle in state st with ack a and zero flag z.
  function automatic logic [20:0] exp_vec(input logic [3:0] st, input bit a, input bit z,
                                          input bit ill);
    logic req = 0, we = 0, io = 0, irw = 0, pce = 0, sa = 0, ext = 0, rd = 0, m2r = 0;
    logic rw = 0, il = 0;
    logic [1:0] ps = 0, sbv = 0, op = 0;
    case (st)
      SF:   begin req = 1; sbv = 2'b01; irw = a; pce = a; end
      SD:   begin sbv = 2'b11; il = ill; end
      SMA:  begin sa = 1; sbv = 2'b10; end
      SMR:  begin req = 1; io = 1; end
      SMWB: begin rw = 1; m2r = 1; end
      SMW:  begin req = 1; io = 1; we = 1; end
      SRX:  begin sa = 1; op = 2'b10; end
      SRW:  begin rw = 1; rd = 1; end
      SBR:  begin sa = 1; op = 2'b01; ps = 2'b01; pce = z; end
      SOX:  begin sa = 1; sbv = 2'b10; ext = 1; op = 2'b11; end
      SOW:  begin rw = 1; end
      SJ:   begin pce = 1; ps = 2'b10; end
      SH:   begin il = 1; end
      default: ;
    endcase
    return {st, req, we, io, irw, pce, ps, sa, sbv, ext, op, rd, m2r, rw, il};
  endfunction

  // Queue a state: waits cycles with ack low, then one with ack high.
  task automatic add_state(input logic [3:0] st, input int waits);
    for (int i = 0; i < waits; i++) steps.push_back('{st, 1'b0});
    steps.push_back('{st, 1'b1});
  endtask

  task automatic test_reset();
    logic [20:0] e;
    bit p;
    step_t s;
    rst = 1; ack = 0; opcode = OP_LW; funct = 0; zero_v = 0; exp_ill = 0;
    sb.push_back(21'h0);
    @(negedge clk);
    e = sb.pop_front(); compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_hold: got %h want %h", obs, e); end
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 2; c++) begin
      sb.push_back(exp_vec(SF, 1'b0, zero_v, 1'b0));
      pc_q.push_back(c == 0);
      @(negedge clk);
      e = sb.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL reset_release%0d: got %h want %h", c, obs, e); end
      p = pc_q.pop_front(); compared++;
      if (d2_pc_en !== p) begin
        mismatched++; $display("FAIL pc_init%0d: got %b want %b", c, d2_pc_en, p);
      end
      @(posedge clk); #1;
    end
    add_state(SF, 0); add_state(SD, 0); add_state(SMA, 0);
    while (steps.size() > 0) begin
      s = steps.pop_front(); ack = s.a;
      sb.push_back(exp_vec(s.st, s.a, zero_v, exp_ill));
      @(negedge clk);
      e = sb.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL reset_lw st%0d: got %h want %h", s.st, obs, e); end
      @(posedge clk); #1;
    end
    ack = 0;
    sb.push_back(exp_vec(SMR, 1'b0, zero_v, 1'b0));
    @(negedge clk);
    e = sb.pop_front(); compared++;
    if (obs !== e) begin mismatched++; $display("FAIL memrd_wait: got %h want %h", obs, e); end
    #2 rst = 1;
    sb.push_back(21'h0);
    #1;
    e = sb.pop_front(); compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_abort: got %h want %h", obs, e); end
    @(posedge clk); #1 rst = 0;
    sb.push_back(exp_vec(SF, 1'b0, zero_v, 1'b0));
    @(negedge clk);
    e = sb.pop_front(); compared++;
    if (obs !== e) begin mismatched++; $display("FAIL reset_refetch: got %h want %h", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [20:0] e;
    step_t s;
    for (int k = 0; k < 2; k++) begin
      opcode = OP_R; funct = (k == 0) ? 6'b100001 : 6'b100011;
      add_state(SF, 0); add_state(SD, 0); add_state(SRX, 0); add_state(SRW, 0);
      while (steps.size() > 0) begin
        s = steps.pop_front(); ack = s.a;
        sb.push_back(exp_vec(s.st, s.a, zero_v, exp_ill));
        @(negedge clk);
        e = sb.pop_front(); compared++;
        if (obs !== e) begin mismatched++; $display("FAIL rtype%0d st%0d: got %h want %h", k, s.st, obs, e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_mem();
    logic [20:0] e;
    step_t s;
    opcode = OP_LW; funct = 6'h15;
    add_state(SF, 2); add_state(SD, 0); add_state(SMA, 0); add_state(SMR, 2); add_state(SMWB, 0);
    while (steps.size() > 0) begin
      s = steps.pop_front(); ack = s.a;
      sb.push_back(exp_vec(s.st, s.a, zero_v, exp_ill));
      @(negedge clk);
      e = sb.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL lw st%0d: got %h want %h", s.st, obs, e); end
      @(posedge clk); #1;
    end
    opcode = OP_SW;
    add_state(SF, 0); add_state(SD, 0); add_state(SMA, 0); add_state(SMW, 1);
    while (steps.size() > 0) begin
      s = steps.pop_front(); ack = s.a;
      sb.push_back(exp_vec(s.st, s.a, zero_v, exp_ill));
      @(negedge clk);
      e = sb.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL sw st%0d: got %h want %h", s.st, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [20:0] e;
    step_t s;
    opcode = OP_BEQ;
    for (int k = 0; k < 2; k++) begin
      zero_v = (k == 0);
      add_state(SF, 0); add_state(SD, 0); add_state(SBR, 0);
      while (steps.size() > 0) begin
        s = steps.pop_front(); ack = s.a;
        sb.push_back(exp_vec(s.st, s.a, zero_v, exp_ill));
        @(negedge clk);
        e = sb.pop_front(); compared++;
        if (obs !== e) begin mismatched++; $display("FAIL beq_z%0b st%0d: got %h want %h", zero_v, s.st, obs, e); end
        @(posedge clk); #1;
      end
    end
    zero_v = 0;
  endtask

  task automatic test_ori_j();
    logic [20:0] e;
    step_t s;
    opcode = OP_ORI;
    add_state(SF, 0); add_state(SD, 0); add_state(SOX, 0); add_state(SOW, 0);
    add_state(SF, 1); add_state(SD, 0); add_state(SJ, 0);
    while (steps.size() > 0) begin
      s = steps.pop_front(); ack = s.a;
      if (s.st == SD && steps.size() == 1) opcode = OP_J;
      sb.push_back(exp_vec(s.st, s.a, zero_v, exp_ill));
      @(negedge clk);
      e = sb.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL ori_j st%0d: got %h want %h", s.st, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [20:0] e;
    step_t s;
    opcode = 6'b111111;
    add_state(SF, 0); add_state(SD, 0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) add_state(SH, 0);
`else
    add_state(SF, 1);
`endif
    exp_ill = 1;
    while (steps.size() > 0) begin
      s = steps.pop_front(); ack = s.a;
      sb.push_back(exp_vec(s.st, s.a, zero_v, exp_ill));
      @(negedge clk);
      e = sb.pop_front(); compared++;
      if (obs !== e) begin mismatched++; $display("FAIL illegal st%0d: got %h want %h", s.st, obs, e); end
      @(posedge clk); #1;
    end
    exp_ill = 0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_ori_j();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle sequencer for the MIPS core executing addu, subu, ori, lw, sw, beq and j over a shared ALU and a single unified memory port. It replaces per-instruction single-cycle decode with a state machine. Each cycle it drives datapath mux selects and enables, and stalls on a req/ack memory handshake. It sits between the instruction register (opcode/funct) and the datapath, and is the only master of the memory port.

Parameters:
RESET_PC_WRITE, 0, when 1 assert pc_write for one cycle after reset release, so the datapath loads its reset vector.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, combinational from datapath
mem_ack  in  1  memory completed the current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  1 = write (sw), 0 = read
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load instruction register
pc_en  out  1  PC load enable = pc_write | (pc_write_cond & zero)
pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
alusrc_a  out  1  0 = PC, 1 = A register
alusrc_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ext_zero  out  1  1 = zero-extend imm (ori)
aluop  out  2  00 add, 01 sub, 10 per funct, 11 or
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = MDR, 0 = ALUOut
regwrite  out  1  register file write enable
illegal  out  1  unsupported opcode/funct decoded
state  out  4  current state, for debug

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BRANCH 8, ORIEX 9, ORIWB 10, JUMP 11, HALT 12.
- rst asserted: state <= FETCH asynchronously. All outputs are forced to 0 while rst is high, including mem_req.
- Outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, aluop=00, pc_src=00. ir_write and pc_write assert only in the cycle mem_ack=1. Go to DECODE on ack, otherwise hold.
- DECODE: alusrc_a=0, alusrc_b=11, aluop=00 (precompute branch target).
  - Next state: lw/sw -> MEMADR; R-type with funct 100001/100011 -> REX; beq -> BRANCH; ori -> ORIEX; j -> JUMP; anything else -> illegal path.
- MEMADR: alusrc_a=1, alusrc_b=10, aluop=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1, mem_we=0. Hold until ack, then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Go to FETCH.
- MEMWR: mem_req=1, iord=1, mem_we=1. Hold until ack, then FETCH.
- REX: alusrc_a=1, alusrc_b=00, aluop=10. Go to RWB.
- RWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
- BRANCH: alusrc_a=1, alusrc_b=00, aluop=01, pc_write_cond=1, pc_src=01. Go to FETCH.
- ORIEX: alusrc_a=1, alusrc_b=10, ext_zero=1, aluop=11. Go to ORIWB.
- ORIWB: regwrite=1, regdst=0. Go to FETCH.
- JUMP: pc_write=1, pc_src=10. Go to FETCH.
- Latency with zero-wait memory (ack in the same cycle as req):
  - addu/subu/ori/sw: 4 cycles
  - lw: 5 cycles
  - beq/j: 3 cycles
- Each memory wait cycle adds 1 cycle. mem_req and the address select stay stable until ack.
- mem_ack while mem_req=0 is ignored.
- Reset during a wait abandons the access: mem_req drops immediately.
- RESET_PC_WRITE=1: the first FETCH after reset additionally asserts pc_write for one cycle, independent of ack.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode/funct goes DECODE -> HALT. HALT asserts illegal=1, issues no requests and has no exit except rst.
- Undefined: an illegal instruction goes DECODE -> FETCH (NOP) and illegal pulses for one cycle in DECODE. HALT is unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants (R 000000, LW 100011, SW 101011, BEQ 000100, ORI 001101, J 000010)
  - funct constants (ADDU 100001, SUBU 100011)
  - aluop and pc_src codes
- One sub-module, ctrl_outdec: purely combinational state -> control-word decode.
- multicycle_ctrl keeps the state register, next-state logic and mem_ack qualification.

Test Plan:
- Reset: rst=1 mid-MEMRD with mem_ack=0 -> mem_req=0 immediately; after release, state=0 and mem_req=1 next cycle.
- addu with ack always 1 -> state sequence 0,1,6,7,0; regwrite=1 only in cycle 4 with regdst=1; aluop=10 in REX.
- lw with ack delayed 2 cycles in both FETCH and MEMRD -> 9 cycles total; mem_req held high with iord stable during each wait; memtoreg=1 in MEMWB.
- beq: zero=1 -> pc_en=1, pc_src=01 in BRANCH; zero=0 -> pc_en=0; both take 3 cycles.
- ori -> ext_zero=1 and aluop=11 in ORIEX; regwrite with regdst=0 in ORIWB. j -> pc_en=1, pc_src=10 in cycle 3.
- opcode 111111 -> with ILLEGAL_TRAP_EN: state=12, illegal stuck at 1, mem_req=0 for 20 cycles. Without it: illegal high only in DECODE, next state=0.
